// File: rtl/ps2_scancode_decoder_pkg.sv
// Shared definitions for the PS/2 scan-code set 2 decoder: prefix/control bytes,
// modifier key codes, parser states and the 18-bit event entry layout.
package ps2_scancode_decoder_pkg;

  localparam logic [7:0] PFX_EXT    = 8'hE0;
  localparam logic [7:0] PFX_BRK    = 8'hF0;
  localparam logic [7:0] PFX_PAUSE  = 8'hE1;

  localparam logic [7:0] CTL_ACK    = 8'hFA;
  localparam logic [7:0] CTL_BAT    = 8'hAA;
  localparam logic [7:0] CTL_ECHO   = 8'hEE;
  localparam logic [7:0] CTL_RESEND = 8'hFE;
  localparam logic [7:0] CTL_ERR0   = 8'h00;
  localparam logic [7:0] CTL_ERR1   = 8'hFF;

  localparam logic [7:0] KEY_LSHIFT = 8'h12;
  localparam logic [7:0] KEY_RSHIFT = 8'h59;
  localparam logic [7:0] KEY_CTRL   = 8'h14;
  localparam logic [7:0] KEY_ALT    = 8'h11;
  localparam logic [7:0] KEY_CAPS   = 8'h58;

  // Pause sends E1 followed by seven more bytes; only the last one emits
  localparam logic [2:0] PAUSE_LEN  = 3'd7;

  localparam int EV_W = 18;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXTBRK,
    ST_PAU
  } ps2_state_e;

  typedef struct packed {
    logic       brk;
    logic       ext;
    logic [7:0] code;
    logic [7:0] ascii;
  } ps2_event_t;

  function automatic logic is_ctrl_byte(input logic [7:0] b);
    return (b == CTL_ACK) || (b == CTL_BAT) || (b == CTL_ECHO) ||
           (b == CTL_RESEND) || (b == CTL_ERR0) || (b == CTL_ERR1);
  endfunction

  function automatic logic is_modifier(input logic [7:0] b);
    return (b == KEY_LSHIFT) || (b == KEY_RSHIFT) || (b == KEY_CTRL) ||
           (b == KEY_ALT) || (b == KEY_CAPS);
  endfunction

endpackage

// File: rtl/ps2_scancode_decoder_evfifo.sv
// Show-ahead synchronous event FIFO; head entry reads as zero while empty.
module ps2_evfifo #(
  parameter int AW = 3,
  parameter int W  = 18
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         clr,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         valid,
  output logic         ovf
);

  localparam int DEPTH = 1 << AW;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          full;
  logic          do_push;
  logic          do_pop;

  assign valid   = (count != '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && valid;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push
  assign do_push = push && (!full || do_pop);
  assign rdata   = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clock) begin
    if (do_push && !clr)
      mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (push && full && !do_pop)
        ovf <= 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ps2_scancode_decoder.sv
// PS/2 scan-code set 2 decoder: parses prefix/pause sequences into key events,
// tracks modifiers, translates makes to ASCII and queues events in a FIFO.
module ps2_scancode_decoder
  import ps2_scancode_decoder_pkg::*;
#(
  parameter int AW  = 3,
  parameter int RPT = 1
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [7:0] kbd,
  input  logic       hit,
  input  logic       rd,
  input  logic       clr,
  output logic       valid,
  output logic [7:0] q_code,
  output logic       q_ext,
  output logic       q_brk,
  output logic [7:0] q_ascii,
  output logic [3:0] mods,
  output logic       ovf
);

  ps2_state_e  state, state_nx;
  logic [2:0]  pau_cnt, pau_cnt_nx;
  logic        emit, em_ext, em_brk, em_pause, bat_seen;
  logic [7:0]  em_code;
  logic        ev_ok, held_now, suppress;
  logic [7:0]  hold_idx;
  logic [255:0] held;
  logic        shift_l, shift_r, ctrl, alt, caps;
  ps2_event_t  ev_nx, stage_q, head;
  logic        stage_push, push_nx;
  logic [EV_W-1:0] head_raw;

  function automatic logic [7:0] ascii_of(input logic [7:0] code, input logic shift,
                                          input logic caps_on, input logic ctrl_on);
    logic [7:0] lo;
    logic [7:0] up;
    logic [7:0] r;
    lo = 8'h00;
    up = 8'h00;
    case (code)
      8'h1C: lo = "a";  8'h32: lo = "b";  8'h21: lo = "c";  8'h23: lo = "d";
      8'h24: lo = "e";  8'h2B: lo = "f";  8'h34: lo = "g";  8'h33: lo = "h";
      8'h43: lo = "i";  8'h3B: lo = "j";  8'h42: lo = "k";  8'h4B: lo = "l";
      8'h3A: lo = "m";  8'h31: lo = "n";  8'h44: lo = "o";  8'h4D: lo = "p";
      8'h15: lo = "q";  8'h2D: lo = "r";  8'h1B: lo = "s";  8'h2C: lo = "t";
      8'h3C: lo = "u";  8'h2A: lo = "v";  8'h1D: lo = "w";  8'h22: lo = "x";
      8'h35: lo = "y";  8'h1A: lo = "z";
      8'h45: begin lo = "0"; up = ")"; end
      8'h16: begin lo = "1"; up = "!"; end
      8'h1E: begin lo = "2"; up = "@"; end
      8'h26: begin lo = "3"; up = "#"; end
      8'h25: begin lo = "4"; up = "$"; end
      8'h2E: begin lo = "5"; up = "%"; end
      8'h36: begin lo = "6"; up = "^"; end
      8'h3D: begin lo = "7"; up = "&"; end
      8'h3E: begin lo = "8"; up = "*"; end
      8'h46: begin lo = "9"; up = "("; end
      8'h0E: begin lo = 8'h60; up = "~"; end
      8'h4E: begin lo = "-"; up = "_"; end
      8'h55: begin lo = "="; up = "+"; end
      8'h54: begin lo = "["; up = "{"; end
      8'h5B: begin lo = "]"; up = "}"; end
      8'h5D: begin lo = "\\"; up = "|"; end
      8'h4C: begin lo = ";"; up = ":"; end
      8'h52: begin lo = "'"; up = "\""; end
      8'h41: begin lo = ","; up = "<"; end
      8'h49: begin lo = "."; up = ">"; end
      8'h4A: begin lo = "/"; up = "?"; end
      8'h5A: lo = 8'h0D;
      8'h66: lo = 8'h08;
      8'h0D: lo = 8'h09;
      8'h76: lo = 8'h1B;
      8'h29: lo = 8'h20;
      default: lo = 8'h00;
    endcase
    if (lo >= "a" && lo <= "z") begin
      r = (shift ^ caps_on) ? (lo - 8'h20) : lo;
      if (ctrl_on)
        r = r & 8'h1F;
    end else if (shift && up != 8'h00) begin
      r = up;
    end else begin
      r = lo;
    end
    return r;
  endfunction

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      pau_cnt <= '0;
    end else if (clr) begin
      state   <= ST_IDLE;
      pau_cnt <= '0;
    end else begin
      state   <= state_nx;
      pau_cnt <= pau_cnt_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    pau_cnt_nx = pau_cnt;
    emit       = 1'b0;
    em_code    = kbd;
    em_ext     = 1'b0;
    em_brk     = 1'b0;
    em_pause   = 1'b0;
    bat_seen   = 1'b0;
    if (hit) begin
      case (state)
        ST_IDLE: begin
          if (kbd == PFX_EXT)
            state_nx = ST_EXT;
          else if (kbd == PFX_BRK)
            state_nx = ST_BRK;
          else if (kbd == PFX_PAUSE) begin
            state_nx   = ST_PAU;
            pau_cnt_nx = PAUSE_LEN;
          end else if (is_ctrl_byte(kbd))
            bat_seen = (kbd == CTL_BAT);
          else
            emit = 1'b1;
        end
        ST_EXT: begin
          if (kbd == PFX_BRK)
            state_nx = ST_EXTBRK;
          else if (kbd != PFX_EXT) begin
            emit     = 1'b1;
            em_ext   = 1'b1;
            state_nx = ST_IDLE;
          end
        end
        ST_BRK: begin
          emit     = 1'b1;
          em_brk   = 1'b1;
          state_nx = ST_IDLE;
        end
        ST_EXTBRK: begin
          emit     = 1'b1;
          em_ext   = 1'b1;
          em_brk   = 1'b1;
          state_nx = ST_IDLE;
        end
        ST_PAU: begin
          if (pau_cnt == 3'd1) begin
            emit     = 1'b1;
            em_pause = 1'b1;
            em_code  = PFX_PAUSE;
            state_nx = ST_IDLE;
          end else
            pau_cnt_nx = pau_cnt - 1'b1;
        end
        default: state_nx = ST_IDLE;
      endcase
    end
  end

  // Extended 12/59 are the fake shifts wrapped around PrtSc and the nav cluster
  assign ev_ok    = emit && !(em_ext && (em_code == KEY_LSHIFT || em_code == KEY_RSHIFT));
  assign hold_idx = {em_ext, kbd[6:0]};
  assign held_now = held[hold_idx];
  assign suppress = (RPT == 0) && !em_brk && !em_pause && !is_modifier(em_code) && held_now;
  assign push_nx  = ev_ok && !suppress && !clr;

  always_comb begin
    ev_nx.brk   = em_brk;
    ev_nx.ext   = em_ext;
    ev_nx.code  = em_code;
    ev_nx.ascii = (em_brk || em_ext || em_pause) ? 8'h00 :
                  ascii_of(em_code, shift_l | shift_r, caps, ctrl);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      held    <= '0;
      shift_l <= 1'b0;
      shift_r <= 1'b0;
      ctrl    <= 1'b0;
      alt     <= 1'b0;
      caps    <= 1'b0;
    end else if (!clr) begin
      if (bat_seen) begin
        shift_l <= 1'b0;
        shift_r <= 1'b0;
        ctrl    <= 1'b0;
        alt     <= 1'b0;
        caps    <= 1'b0;
      end
      if (ev_ok && !em_pause) begin
        held[hold_idx] <= !em_brk;
        case (em_code)
          KEY_LSHIFT: shift_l <= !em_brk;
          KEY_RSHIFT: shift_r <= !em_brk;
          KEY_CTRL:   ctrl    <= !em_brk;
          KEY_ALT:    alt     <= !em_brk;
          KEY_CAPS:   if (!em_brk && !held_now) caps <= !caps;
          default:    ;
        endcase
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stage_push <= 1'b0;
      stage_q    <= '0;
    end else begin
      stage_push <= push_nx;
      stage_q    <= ev_nx;
    end
  end

  ps2_evfifo #(.AW(AW), .W(EV_W)) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .clr     (clr),
    .push    (stage_push),
    .wdata   (stage_q),
    .pop     (rd),
    .rdata   (head_raw),
    .valid   (valid),
    .ovf     (ovf)
  );

  assign head    = head_raw;
  assign q_code  = head.code;
  assign q_ext   = head.ext;
  assign q_brk   = head.brk;
  assign q_ascii = head.ascii;
  assign mods    = {caps, alt, ctrl, shift_l | shift_r};

endmodule
